// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_link
// endpoint and its RX core.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a modulus n, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_link_if.sv
// Bridge-side handshake bundle of the UART endpoint:
// byte request/status towards TX, strobes from RX.
interface uart_link_if #(
  parameter int DATA_LEN = 8
);

  logic                tx_start;
  logic [DATA_LEN-1:0] tx_data;
  logic                tx_busy;
  logic                tx_done;
  logic [DATA_LEN-1:0] rx_data;
  logic                rx_valid;
  logic                rx_error;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  rx_data,
    input  rx_valid,
    input  rx_error
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output rx_data,
    output rx_valid,
    output rx_error
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit
// sampling FSM, shift register, output strobes.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_LEN     = 8,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_error
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int IW = cnt_w(DATA_LEN);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF =
    CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_LEN - 1);

  rx_state_e           state_q, state_d;
  logic                meta_q, meta_d;
  logic                rx_s_q, rx_s_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_LEN-1:0] sh_q, sh_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  // Next state: synchroniser shift, then frame FSM on rx_s.
  always_comb begin
    meta_d  = rx;
    rx_s_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_s_q == START_BIT) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (rx_s_q == START_BIT) ?
                    RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          sh_d[DATA_LEN-1] = rx_s_q;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q == STOP_BIT) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s_q == LINE_IDLE) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State register; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      meta_q  <= LINE_IDLE;
      rx_s_q  <= LINE_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      rx_s_q  <= rx_s_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_error = error_q;

endmodule

// File: rtl/uart_link.sv
// Full-duplex 8N1 UART endpoint: TX FSM here,
// receive path delegated to uart_rx_core.
module uart_link
  import uart_pkg::*;
#(
  parameter int DATA_LEN     = 8,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  uart_link_if.slave bus,
  output logic       tx,
  input  logic       rx
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int IW = cnt_w(DATA_LEN);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(DATA_LEN - 1);

  tx_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_LEN-1:0] sh_q, sh_d, sh_nx;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_LEN-1:0] rx_data_w;
  logic                rx_valid_w;
  logic                rx_error_w;

  // Next state: each bit is held CLKS_PER_BIT cycles,
  // tx_d is the level for the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sh_nx   = sh_q >> 1;
    unique case (state_q)
      TX_IDLE: begin
        tx_d = LINE_IDLE;
        if (bus.tx_start) begin
          sh_d    = bus.tx_data;
          busy_d  = 1'b1;
          tx_d    = START_BIT;
          cnt_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = sh_q[0];
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            tx_d    = STOP_BIT;
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_nx;
            tx_d  = sh_nx[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = LINE_IDLE;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // TX state register, line idles high in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_rx_core #(
    .DATA_LEN    (DATA_LEN),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst_n   (reset),
    .rx      (rx),
    .rx_data (rx_data_w),
    .rx_valid(rx_valid_w),
    .rx_error(rx_error_w)
  );

  assign tx           = tx_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.rx_data  = rx_data_w;
  assign bus.rx_valid = rx_valid_w;
  assign bus.rx_error = rx_error_w;

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: reset/idle, TX
// framing, RX vectors, glitch/reset, loopback.
module tb_uart_link;

  localparam int CPB    = 87;
  localparam int DL     = 8;
  localparam int FRAME  = (DL + 2) * CPB;
  localparam int RX_LAT = 2 + CPB / 2 + (DL + 1) * CPB + 1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } rx_vec_t;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic rx_drv;
  logic loop_en;
  logic rx_in;

  uart_link_if #(.DATA_LEN(DL)) bus ();

  assign rx_in = loop_en ? tx : rx_drv;

  uart_link #(
    .DATA_LEN    (DL),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .rx   (rx_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid, n_err, n_done;
  int v_cyc, e_cyc, d_cyc;
  logic [7:0] rxq[$];
  rx_vec_t rxv[4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic check_rng(input string name,
                           input int act,
                           input int lo,
                           input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rx_valid === 1'b1) begin
      n_valid++;
      v_cyc = cyc;
      rxq.push_back(bus.rx_data);
    end
    if (bus.rx_error === 1'b1) begin
      n_err++;
      e_cyc = cyc;
    end
    if (bus.tx_done === 1'b1) begin
      n_done++;
      d_cyc = cyc;
    end
  endtask

  task automatic clear();
    n_valid = 0;
    n_err   = 0;
    n_done  = 0;
    v_cyc   = -100000;
    e_cyc   = -100000;
    d_cyc   = -100000;
    rxq.delete();
  endtask

  task automatic send_rx(input logic [7:0] b,
                         input logic stop,
                         output int e0);
    rx_drv = 1'b0;
    step();
    e0 = cyc;
    repeat (CPB - 1) step();
    for (int i = 0; i < DL; i++) begin
      rx_drv = b[i];
      repeat (CPB) step();
    end
    rx_drv = stop;
    repeat (CPB) step();
    if (!stop) repeat (300) step();
    rx_drv = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] b,
                          input int k);
    int n;
    int bad[10];
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    foreach (bad[j]) bad[j] = 0;
    clear();
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    n = cyc;
    check($sformatf("tx%0d_busy", k), bus.tx_busy, 1);
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== fr[i / CPB]) bad[i / CPB]++;
      if (i == 399) begin
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
      end else begin
        bus.tx_start = 1'b0;
      end
      step();
    end
    bus.tx_start = 1'b0;
    check($sformatf("tx%0d_done", k), bus.tx_done, 1);
    check($sformatf("tx%0d_done_at", k), d_cyc - n, FRAME);
    check($sformatf("tx%0d_busy_end", k), bus.tx_busy, 0);
    for (int j = 0; j < 10; j++)
      check($sformatf("tx%0d_bit%0d_bad", k, j), bad[j], 0);
    repeat (200) step();
    check($sformatf("tx%0d_done_cnt", k), n_done, 1);
    check($sformatf("tx%0d_no_queue", k), bus.tx_busy, 0);
    check($sformatf("tx%0d_idle", k), tx, 1);
  endtask

  initial begin
    int e0;
    int bad;
    int t;
    logic [7:0] lb[3];
    logic [7:0] got;

    rxv[0] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    rxv[1] = '{8'h55, 1'b0, 0, 1, 8'h3C};
    rxv[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    rxv[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h96;

    reset        = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    rx_drv       = 1'b1;
    loop_en      = 1'b0;
    clear();

    repeat (5) step();
    check("rst_tx", tx, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_valid", bus.rx_valid, 0);
    check("rst_error", bus.rx_error, 0);
    check("rst_rx_data", bus.rx_data, 0);
    reset = 1'b1;

    clear();
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    check("idle_tx", bad, 0);
    check("idle_valid", n_valid, 0);
    check("idle_err", n_err, 0);
    check("idle_done", n_done, 0);
    check("idle_rx_data", bus.rx_data, 0);

    tx_frame(8'hA5, 0);
    tx_frame(8'h3C, 1);

    for (int k = 0; k < 4; k++) begin
      clear();
      send_rx(rxv[k].data, rxv[k].stop, e0);
      repeat (300) step();
      check($sformatf("rx%0d_valid_cnt", k),
            n_valid, rxv[k].exp_valid);
      check($sformatf("rx%0d_err_cnt", k),
            n_err, rxv[k].exp_err);
      check($sformatf("rx%0d_data", k),
            bus.rx_data, rxv[k].exp_data);
      if (rxv[k].exp_valid == 1)
        check_rng($sformatf("rx%0d_lat", k),
                  v_cyc - e0, RX_LAT - 1, RX_LAT + 1);
      else
        check_rng($sformatf("rx%0d_err_lat", k),
                  e_cyc - e0, RX_LAT - 1, RX_LAT + 1);
    end

    clear();
    rx_drv = 1'b0;
    repeat (20) step();
    rx_drv = 1'b1;
    repeat (200) step();
    check("glitch_valid", n_valid, 0);
    check("glitch_err", n_err, 0);

    clear();
    rx_drv = 1'b0;
    repeat (CPB) step();
    rx_drv = 1'b1;
    repeat (CPB) step();
    rx_drv = 1'b0;
    repeat (CPB / 2) step();
    reset = 1'b0;
    repeat (3) step();
    check("midrst_rx_data", bus.rx_data, 0);
    check("midrst_tx", tx, 1);
    rx_drv = 1'b1;
    reset  = 1'b1;
    repeat (1200) step();
    check("midrst_valid", n_valid, 0);
    check("midrst_err", n_err, 0);
    clear();
    send_rx(8'h7E, 1'b1, e0);
    repeat (100) step();
    check("post_rst_valid", n_valid, 1);
    check("post_rst_data", bus.rx_data, 8'h7E);
    check_rng("post_rst_lat", v_cyc - e0,
              RX_LAT - 1, RX_LAT + 1);

    loop_en = 1'b1;
    repeat (10) step();
    clear();
    bus.tx_data  = lb[0];
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    for (int k = 1; k < 3; k++) begin
      t = 0;
      while (bus.tx_done !== 1'b1 && t < 2000) begin
        step();
        t++;
      end
      check($sformatf("lb_done%0d", k), bus.tx_done, 1);
      bus.tx_data  = lb[k];
      bus.tx_start = 1'b1;
      step();
      bus.tx_start = 1'b0;
      check($sformatf("lb_gap_busy%0d", k),
            bus.tx_busy, 1);
      check($sformatf("lb_gap_tx%0d", k), tx, 0);
    end
    t = 0;
    while (bus.tx_done !== 1'b1 && t < 2000) begin
      step();
      t++;
    end
    check("lb_done_last", bus.tx_done, 1);
    repeat (200) step();
    check("lb_rx_cnt", rxq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      got = (k < rxq.size()) ? rxq[k] : 8'bx;
      check($sformatf("lb_rx_data%0d", k), got, lb[k]);
    end
    check("lb_err", n_err, 0);
    check("lb_done_cnt", n_done, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
